// File: rtl/ca3_pkg.sv
// Shared definitions for the one-hot controller and its iteration datapath:
// default widths and the bit positions of the decoded strobe vector.
package ca3_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 3;

  // Strobe vector layout shared with the controller's state decode
  localparam int STB_INIT  = 0;
  localparam int STB_CNT   = 1;
  localparam int STB_SHIFT = 2;
  localparam int STB_W     = 3;

  typedef logic [STB_W-1:0] strobe_t;

endpackage : ca3_pkg

// File: rtl/loop_counter.sv
// Iteration up-counter with synchronous clear/enable and terminal-count flag.
// Define LOOP_CNT_SAT_EN to saturate at all ones instead of wrapping.
module loop_counter
  import ca3_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             co
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             co_s;

  assign co_s = (cnt_r == {CNT_W{1'b1}});

  // Increment value; the saturating build parks at the terminal count
  always_comb begin
    cnt_inc_s = cnt_r + CNT_W'(1);
`ifdef LOOP_CNT_SAT_EN
    if (co_s) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
`endif
  end

  // Counter register: reset > clear > enable > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign co  = co_s;

endmodule : loop_counter

// File: rtl/loop_counter_datapath.sv
// Iteration datapath downstream of the one-hot controller: loadable left-shift
// register plus loop counter whose co closes the loop. Option: LOOP_CNT_SAT_EN.
module loop_counter_datapath
  import ca3_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              cnt_en,
  input  logic              shift_en,
  input  logic              sin,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              msb_out,
  output logic [CNT_W-1:0]  cnt,
  output logic              co
);

  strobe_t           stb_s;
  logic [DATA_W-1:0] data_r;

  // Pack strobes in the controller's vector layout
  always_comb begin
    stb_s            = {STB_W{1'b0}};
    stb_s[STB_INIT]  = init;
    stb_s[STB_CNT]   = cnt_en;
    stb_s[STB_SHIFT] = shift_en;
  end

  // Data register: init load wins over shift; old MSB is dropped on shift
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {DATA_W{1'b0}};
    end else if (stb_s[STB_INIT]) begin
      data_r <= data_in;
    end else if (stb_s[STB_SHIFT]) begin
      data_r <= {data_r[DATA_W-2:0], sin};
    end else begin
      data_r <= data_r;
    end
  end

  loop_counter #(
    .CNT_W (CNT_W)
  ) u_loop_counter (
    .clk (clk),
    .rst (rst),
    .clr (stb_s[STB_INIT]),
    .en  (stb_s[STB_CNT]),
    .cnt (cnt),
    .co  (co)
  );

  assign data_out = data_r;
  assign msb_out  = data_r[DATA_W-1];

endmodule : loop_counter_datapath
